// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 720p60 raster constants and total helpers shared by the sync and colour stages
package vga_timing_pkg;

    localparam int ADDR_W = 11;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam bit H_POL_720P    = 1'b1;
    localparam bit V_POL_720P    = 1'b1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register of DEPTH stages (0 = wire) with async reset value
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
        $error("vga_delay_line: DEPTH must be 0..4");
    end

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, en};
        assign dout      = din;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d = stage_q;
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster counters, pixel address bus and delayed active/sync/frame_start decodes
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter bit H_POL    = H_POL_720P,
    parameter bit V_POL    = V_POL_720P,
    parameter int PIPE_DLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] col_addr,
    output logic [ADDR_W-1:0] row_addr,
    output logic              ready,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 2047");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_sync_gen: PIPE_DLY must be 0..4");
    end

    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_ACT_C  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_ACT_C  = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] HS_BEG   = ADDR_W'(H_ACTIVE + H_FP);
    localparam logic [ADDR_W-1:0] HS_END   = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ADDR_W-1:0] VS_BEG   = ADDR_W'(V_ACTIVE + V_FP);
    localparam logic [ADDR_W-1:0] VS_END   = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_addr = col_q;
    assign row_addr = row_q;

    logic act, hs, vs, fs;
    logic hs_lvl, vs_lvl;

    always_comb begin
        act    = (col_q < H_ACT_C) && (row_q < V_ACT_C);
        hs     = (col_q >= HS_BEG) && (col_q < HS_END);
        vs     = (row_q >= VS_BEG) && (row_q < VS_END);
        fs     = (col_q == '0) && (row_q == '0);
        hs_lvl = hs ? H_POL : ~H_POL;
        vs_lvl = vs ? V_POL : ~V_POL;
    end

    // Reset value keeps every stage inactive, so no frame_start can leak out before pixel (0,0).
    logic [3:0] dly_out;

    vga_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (4),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL, 1'b0})
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   ({act, hs_lvl, vs_lvl, fs}),
        .dout  (dly_out)
    );

    assign {ready, hsync, vsync, frame_start} = dly_out;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench on a reduced raster with PIPE_DLY 0, 1 and 3 builds
module tb_vga_sync_gen;

    localparam int HA = 16, HFP = 4, HSW = 3, HBP = 5;
    localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam bit HP = 1'b1, VP = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;

    logic [10:0] col0, row0, col1, row1, col3, row3;
    logic rdy0, hs0, vs0, fs0;
    logic rdy1, hs1, vs1, fs1;
    logic rdy3, hs3, vs3, fs3;

    always #5 clk = ~clk;

    vga_sync_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .H_POL(HP), .V_POL(VP), .PIPE_DLY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .col_addr(col0), .row_addr(row0),
        .ready(rdy0), .hsync(hs0), .vsync(vs0), .frame_start(fs0));

    vga_sync_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .H_POL(HP), .V_POL(VP), .PIPE_DLY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .col_addr(col1), .row_addr(row1),
        .ready(rdy1), .hsync(hs1), .vsync(vs1), .frame_start(fs1));

    vga_sync_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                   .H_POL(HP), .V_POL(VP), .PIPE_DLY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .col_addr(col3), .row_addr(row3),
        .ready(rdy3), .hsync(hs3), .vsync(vs3), .frame_start(fs3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n = enabled clocks since reset; outputs are the decode of pixel n-d.
    int n = 0;
    bit adv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n   = 0;
            adv = 1'b0;
        end else begin
            adv = en;
            if (en) n++;
        end
    end

    function automatic logic [3:0] exp_out(input int cnt, input int d);
        int p, c, r;
        if (cnt < d) return {1'b0, ~HP, ~VP, 1'b0};
        p = cnt - d;
        c = p % HT;
        r = (p / HT) % VT;
        return {(c < HA && r < VA),
                ((c >= HA + HFP && c < HA + HFP + HSW) ? HP : ~HP),
                ((r >= VA + VFP && r < VA + VFP + VSW) ? VP : ~VP),
                (c == 0 && r == 0)};
    endfunction

    logic prev_rdy [3] = '{1'b0, 1'b0, 1'b0};
    logic prev_hs  [3] = '{1'b0, 1'b0, 1'b0};

    task automatic check_dut(input int idx, input int d, input logic [10:0] col, input logic [10:0] row,
                             input logic rdy, input logic hs, input logic vs, input logic fs);
        logic [3:0] e;
        e = exp_out(n, d);
        chk($sformatf("d%0d_col", d), col, n % HT);
        chk($sformatf("d%0d_row", d), row, (n / HT) % VT);
        chk($sformatf("d%0d_ready", d), rdy, e[3]);
        chk($sformatf("d%0d_hsync", d), hs, e[2]);
        chk($sformatf("d%0d_vsync", d), vs, e[1]);
        chk($sformatf("d%0d_frame_start", d), fs, e[0]);
        if (adv) begin
            if (rdy && !prev_rdy[idx]) chk($sformatf("d%0d_ready_rise_col", d), col, d % HT);
            if (hs && !prev_hs[idx])   chk($sformatf("d%0d_hsync_rise_col", d), col, (HA + HFP + d) % HT);
            if (!hs && prev_hs[idx])   chk($sformatf("d%0d_hsync_fall_col", d), col, (HA + HFP + HSW + d) % HT);
        end
        prev_rdy[idx] = rdy;
        prev_hs[idx]  = hs;
    endtask

    bit seen_fs = 1'b0;
    int frames_checked = 0;
    int f_cycles = 0, f_ready = 0, f_vsync = 0;

    always @(negedge clk) begin
        check_dut(0, 0, col0, row0, rdy0, hs0, vs0, fs0);
        check_dut(1, 1, col1, row1, rdy1, hs1, vs1, fs1);
        check_dut(2, 3, col3, row3, rdy3, hs3, vs3, fs3);
        if (!rst_n) begin
            seen_fs = 1'b0;
        end else if (adv) begin
            if (fs1) begin
                if (seen_fs) begin
                    chk("frame_interval", f_cycles, FT);
                    chk("frame_ready_cycles", f_ready, HA * VA);
                    chk("frame_vsync_cycles", f_vsync, VSW * HT);
                    frames_checked++;
                end
                seen_fs  = 1'b1;
                f_cycles = 0;
                f_ready  = 0;
                f_vsync  = 0;
            end
            f_cycles++;
            f_ready += int'(rdy1);
            f_vsync += int'(vs1 == VP);
        end
    end

    task automatic wait_pos(input int c, input int r);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (col1 == 11'(c) && row1 == 11'(r)) return;
        end
        chk($sformatf("timeout_waiting_col%0d_row%0d", c, r), 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", col1, 0);
        chk("rst_row", row1, 0);
        chk("rst_ready", rdy1, 0);
        chk("rst_hsync", hs1, 0);
        chk("rst_vsync", vs1, 0);
        chk("rst_frame_start", fs1, 0);
        chk("rst_d3_frame_start", fs3, 0);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("first_col", col1, 1);
        chk("first_ready", rdy1, 1);
        chk("first_frame_start", fs1, 1);
        chk("first_d3_ready", rdy3, 0);

        wait_pos(20, 7);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_col", col1, 0);
        chk("async_rst_row", row1, 0);
        chk("async_rst_ready", rdy1, 0);
        chk("async_rst_hsync", hs1, 0);
        chk("async_rst_vsync", vs1, 0);
        chk("async_rst_d3_col", col3, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        wait_pos(10, 2);
        #1 en = 1'b0;
        repeat (17) begin
            @(negedge clk);
            chk("stall_col", col1, 10);
            chk("stall_row", row1, 2);
            chk("stall_ready", rdy1, 1);
            chk("stall_hsync", hs1, 0);
            chk("stall_frame_start", fs1, 0);
        end
        #1 en = 1'b1;
        @(negedge clk);
        chk("resume_col", col1, 11);

        wait_pos(HT - 1, 5);
        @(negedge clk);
        chk("line_wrap_col", col1, 0);
        chk("line_wrap_row", row1, 6);

        wait_pos(HT - 1, VT - 1);
        @(negedge clk);
        chk("frame_wrap_col", col1, 0);
        chk("frame_wrap_row", row1, 0);
        @(negedge clk);
        chk("wrap_frame_start", fs1, 1);
        @(negedge clk);
        chk("wrap_frame_start_once", fs1, 0);

        repeat (2 * FT + 10) @(negedge clk);
        chk("frames_measured_ge2", int'(frames_checked >= 3), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. It runs horizontal and vertical counters over a full video frame and drives the pixel address bus (`col_addr`, `row_addr`) and the `ready` active-video qualifier consumed by the pixel colour stage. It also generates `hsync`/`vsync` and a `frame_start` marker, delayed to line up with the colour stage's registered output. Default timing is 1280x720 @ 60 Hz on a 74.25 MHz `clk`.

## Interface
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, 110: horizontal front porch, clocks
- `H_SYNC`, 40: hsync pulse width, clocks
- `H_BP`, 220: horizontal back porch, clocks
- `V_ACTIVE`, 720: visible lines per frame
- `V_FP`, 5: vertical front porch, lines
- `V_SYNC`, 5: vsync pulse width, lines
- `V_BP`, 20: vertical back porch, lines
- `H_POL`, 1: hsync active level
- `V_POL`, 1: vsync active level
- `PIPE_DLY`, 1: cycles of delay from address outputs to `ready`/`hsync`/`vsync`/`frame_start`; legal range 0..4
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  pixel clock enable; 0 stalls the whole block
- `col_addr`  out  11  horizontal counter, 0..H_TOTAL-1
- `row_addr`  out  11  vertical counter, 0..V_TOTAL-1
- `ready`  out  1  active-video qualifier, delayed by PIPE_DLY
- `hsync`  out  1  horizontal sync, delayed by PIPE_DLY
- `vsync`  out  1  vertical sync, delayed by PIPE_DLY
- `frame_start`  out  1  one-cycle pulse for pixel (0,0), delayed by PIPE_DLY

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750). Both totals must be ≤ 2047; this is an elaboration-time check.
- Line order is active, front porch, sync, back porch, for both axes.
- `col_addr` and `row_addr` are registers, output directly.
  - On each clk with en=1, col advances by 1.
  - At col = H_TOTAL-1, col wraps to 0 and row advances by 1.
  - At row = V_TOTAL-1 on the same wrap, row also wraps to 0.
  - No other wrap exists.
- Undelayed decodes, as functions of the current (col, row):
  - act = col < H_ACTIVE && row < V_ACTIVE
  - hs = H_ACTIVE+H_FP ≤ col < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ row < V_ACTIVE+V_FP+V_SYNC
  - fs = (col==0 && row==0)
- vsync changes only at col wrap, because it is a function of row only.
- Outputs are driven through a PIPE_DLY-stage shift register:
  - `ready` = act, `hsync` = hs ? H_POL : !H_POL, `vsync` = vs ? V_POL : !V_POL, `frame_start` = fs.
  - Each stage is taken PIPE_DLY enabled cycles earlier.
  - PIPE_DLY=0 means the outputs are a combinational decode of the counter registers.
- en=0: counters and every delay stage hold their values, and outputs stay static.

## Timing
- Reset values, applied immediately on rst_n low (including mid-frame):
  - col_addr=0, row_addr=0, ready=0, frame_start=0
  - hsync=!H_POL, vsync=!V_POL
  - all delay stages hold the inactive values above
- First enabled clk after reset release: col_addr=1. With PIPE_DLY=1, ready=1 and frame_start=1 on this same cycle, tagging pixel (0,0).
- A delay stage loaded from reset never produces a spurious frame_start; the first frame_start is for pixel (0,0).
- Per line: exactly H_SYNC cycles of hsync active. Per frame: exactly V_SYNC×H_TOTAL cycles of vsync active.
- Per frame: exactly H_ACTIVE×V_ACTIVE ready cycles and exactly one frame_start pulse.
- Throughput is one pixel per enabled clk. No backpressure beyond en.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 720p60 constants (active, porch and sync values, polarities)
  - H_TOTAL/V_TOTAL helper functions
  - the 11-bit address width constant
- The color stage shares this package.
- Sub-module `vga_delay_line`: parameterised depth 0..4 and width (4 bits here), with en and asynchronous reset value.

## Test plan
- Reset check (PIPE_DLY=1): assert rst_n low mid-line at col 700, row 300 → col_addr=0, row_addr=0, ready=0, hsync=0, vsync=0 within the same cycle, without a clock edge.
- Line timing (PIPE_DLY=1):
  - hsync is high on exactly the 40 cycles where col_addr is 1391..1430.
  - ready is high on the cycles where col_addr is 1..1280 of row 0.
- Line and frame wrap:
  - col 1649 / row 5 is followed by col 0 / row 6.
  - col 1649 / row 749 is followed by col 0 / row 0.
  - frame_start pulses on the next cycle, once only.
- Frame totals over two full frames: 921600 ready cycles per frame, 8250 vsync-high cycles per frame, 1237500 cycles between frame_start pulses.
- en stall: drop en for 17 cycles at col 1000 → all outputs frozen. Resume → col 1001 on the next enabled clk, and the totals are unchanged.
- PIPE_DLY=0 and PIPE_DLY=3 builds:
  - ready rises at col_addr 0 (PIPE_DLY=0) or at col_addr 3 (PIPE_DLY=3) of row 0.
  - hsync edges shift by the same amount.
